// File: rtl/alarm_axil_pkg.sv
// +--------------------------------------------------------------------------+
// | alarm_axil_pkg : shared response codes and FSM state types               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package alarm_axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/alarm_axil_wstrb_merge.sv
// +--------------------------------------------------------------------------+
// | alarm_axil_wstrb_merge : byte-wise merge of old value and write data     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module alarm_axil_wstrb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_value,
  input  logic [DATA_WIDTH-1:0]   new_value,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  for (genvar b = 0; b < DATA_WIDTH / 8; b++) begin : g_byte
    assign merged[8*b +: 8] = strb[b] ? new_value[8*b +: 8] : old_value[8*b +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/alarm_axil_regs.sv
// +--------------------------------------------------------------------------+
// | alarm_axil_regs : AXI4-Lite register file for the alarm peripheral       |
// | Optional macro ALARM_AXIL_WR_PULSE_EN adds per-register write pulses.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module alarm_axil_regs
  import alarm_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic [2:0]                     s_axi_awprot,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic [2:0]                     s_axi_arprot,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
`ifdef ALARM_AXIL_WR_PULSE_EN
  ,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
`endif
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;

  wr_state_t wr_state, wr_state_next;
  rd_state_t rd_state, rd_state_next;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  aw_held, w_held;
  logic [IDX_W-1:0]      aw_idx_held;
  logic [DATA_WIDTH-1:0] wdata_held;
  logic [STRB_W-1:0]     wstrb_held;

  logic                  aw_fire, w_fire, ar_fire, wr_commit;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_data_eff, wr_old, wr_merged, rd_value;
  logic [STRB_W-1:0]     wr_strb_eff;
  logic [NUM_REGS-1:0]   wr_sel, rd_sel;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Readies are gated by reset so they stay low throughout the reset cycle.
  assign s_axi_awready = !reset && (wr_state == W_IDLE) && !aw_held;
  assign s_axi_wready  = !reset && (wr_state == W_IDLE) && !w_held;
  assign s_axi_arready = !reset && (rd_state == R_IDLE);
  assign s_axi_bvalid  = (wr_state == W_RESP);
  assign s_axi_rvalid  = (rd_state == R_DATA);

  assign aw_fire   = s_axi_awvalid && s_axi_awready;
  assign w_fire    = s_axi_wvalid && s_axi_wready;
  assign ar_fire   = s_axi_arvalid && s_axi_arready;
  assign wr_commit = (wr_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);

  assign wr_idx      = aw_held ? aw_idx_held : s_axi_awaddr[ADDR_WIDTH-1:2];
  assign wr_data_eff = w_held ? wdata_held : s_axi_wdata;
  assign wr_strb_eff = w_held ? wstrb_held : s_axi_wstrb;
  assign rd_idx      = s_axi_araddr[ADDR_WIDTH-1:2];

  // Decoded selects double as range checks: an all-zero select means SLVERR.
  always_comb begin
    wr_sel   = '0;
    rd_sel   = '0;
    wr_old   = '0;
    rd_value = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i)) begin
        wr_sel[i] = 1'b1;
        wr_old    = regs[i];
      end
      if (rd_idx == IDX_W'(i)) begin
        rd_sel[i] = 1'b1;
        rd_value  = regs[i];
      end
    end
  end

  alarm_axil_wstrb_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .old_value (wr_old),
    .new_value (wr_data_eff),
    .strb      (wr_strb_eff),
    .merged    (wr_merged)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_state_next;
      rd_state <= rd_state_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state;
    rd_state_next = rd_state;
    case (wr_state)
      W_IDLE: if (wr_commit) wr_state_next = W_RESP;
      W_RESP: if (s_axi_bready) wr_state_next = W_IDLE;
    endcase
    case (rd_state)
      R_IDLE: if (ar_fire) rd_state_next = R_DATA;
      R_DATA: if (s_axi_rready) rd_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_idx_held <= '0;
      wdata_held  <= '0;
      wstrb_held  <= '0;
      s_axi_bresp <= AXI_RESP_OKAY;
      s_axi_rdata <= '0;
      s_axi_rresp <= AXI_RESP_OKAY;
    end else begin
      if (wr_commit) begin
        aw_held     <= 1'b0;
        w_held      <= 1'b0;
        s_axi_bresp <= (|wr_sel) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end else begin
        if (aw_fire) begin
          aw_held     <= 1'b1;
          aw_idx_held <= s_axi_awaddr[ADDR_WIDTH-1:2];
        end
        if (w_fire) begin
          w_held     <= 1'b1;
          wdata_held <= s_axi_wdata;
          wstrb_held <= s_axi_wstrb;
        end
      end
      if (ar_fire) begin
        s_axi_rdata <= rd_value;
        s_axi_rresp <= (|rd_sel) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        regs[i] <= '0;
      end else if (wr_commit && wr_sel[i]) begin
        regs[i] <= wr_merged;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

`ifdef ALARM_AXIL_WR_PULSE_EN
  // Registered alongside the array so the pulse lines up with the new value.
  always_ff @(posedge clock) begin
    if (reset) begin
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= wr_commit ? wr_sel : '0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alarm_axil_regs.sv
// +--------------------------------------------------------------------------+
// | tb_alarm_axil_regs : self-checking bench with transaction-level model    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alarm_axil_regs;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   awaddr = '0, araddr = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] reg_out;
`ifdef ALARM_AXIL_WR_PULSE_EN
  logic [3:0]   pulse;
`endif

  always #5 clk = ~clk;

  alarm_axil_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(4)) dut (
    .clock(clk), .reset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_out(reg_out)
`ifdef ALARM_AXIL_WR_PULSE_EN
    , .reg_wr_pulse(pulse)
`endif
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: pending request flags, response slots, register image.
  logic [31:0] m_regs [4];
  logic [31:0] m_pre  [4];
  bit          started = 0;
  bit          m_aw_pend, m_w_pend, m_bbusy, m_rbusy;
  int          m_aw_idx, r_idx;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb, m_pulse;
  logic [1:0]  m_bresp, m_rresp;
  bit          aw_acc_now, w_acc_now, ar_acc_now, b_done_now, r_done_now;

  always @(posedge clk) begin
    aw_acc_now = 0; w_acc_now = 0; ar_acc_now = 0; b_done_now = 0; r_done_now = 0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      m_aw_pend = 0; m_w_pend = 0; m_bbusy = 0; m_rbusy = 0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0; m_pulse = '0;
      started = 1;
    end else begin
      m_pre = m_regs;
      m_pulse = '0;
      if (m_bbusy) begin
        if (bready) begin m_bbusy = 0; b_done_now = 1; end
      end else begin
        if (awvalid && !m_aw_pend) begin aw_acc_now = 1; m_aw_pend = 1; m_aw_idx = int'(awaddr[4:2]); end
        if (wvalid && !m_w_pend) begin w_acc_now = 1; m_w_pend = 1; m_wdata = wdata; m_wstrb = wstrb; end
        if (m_aw_pend && m_w_pend) begin
          if (m_aw_idx < 4) begin
            for (int b = 0; b < 4; b++)
              if (m_wstrb[b]) m_regs[m_aw_idx][8*b +: 8] = m_wdata[8*b +: 8];
            m_bresp = 2'b00;
            m_pulse[m_aw_idx] = 1'b1;
          end else begin
            m_bresp = 2'b10;
          end
          m_bbusy = 1; m_aw_pend = 0; m_w_pend = 0;
        end
      end
      if (m_rbusy) begin
        if (rready) begin m_rbusy = 0; r_done_now = 1; end
      end else if (arvalid) begin
        ar_acc_now = 1; m_rbusy = 1;
        r_idx = int'(araddr[4:2]);
        m_rdata = (r_idx < 4) ? m_pre[r_idx] : 32'h0;
        m_rresp = (r_idx < 4) ? 2'b00 : 2'b10;
      end
    end
  end

  logic [1:0]  last_bresp, last_rresp;
  logic [31:0] last_rdata;
  int          pulse_cycles = 0;
  logic [3:0]  last_pulse = '0;

  always @(negedge clk) begin
    if (started) begin
      chk("awready", awready, !rst && !m_bbusy && !m_aw_pend);
      chk("wready",  wready,  !rst && !m_bbusy && !m_w_pend);
      chk("arready", arready, !rst && !m_rbusy);
      chk("bvalid",  bvalid,  m_bbusy);
      chk("rvalid",  rvalid,  m_rbusy);
      if (m_bbusy) chk("bresp", bresp, m_bresp);
      if (m_rbusy) begin
        chk("rdata", rdata, m_rdata);
        chk("rresp", rresp, m_rresp);
      end
      chk("reg_out", reg_out, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
`ifdef ALARM_AXIL_WR_PULSE_EN
      chk("pulse", pulse, m_pulse);
      if (pulse != 4'b0) begin pulse_cycles++; last_pulse = pulse; end
`endif
    end
    if (bvalid && bready) last_bresp = bresp;
    if (rvalid && rready) begin last_rdata = rdata; last_rresp = rresp; end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
    bit got_aw = 0, got_w = 0, got_b = 0;
    int k = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!got_b && k < 60) begin
      awvalid = !got_aw && (k >= aw_dly);
      wvalid  = !got_w && (k >= w_dly);
      step();
      k++;
      if (aw_acc_now) got_aw = 1;
      if (w_acc_now)  got_w = 1;
      if (b_done_now) got_b = 1;
    end
    awvalid = 0; wvalid = 0;
    chk("write_done", got_b, 1'b1);
  endtask

  task automatic axi_read(input logic [4:0] a);
    bit got = 0;
    int k = 0;
    araddr = a; arvalid = 1; rready = 1;
    while (!got && k < 20) begin step(); k++; got = ar_acc_now; end
    arvalid = 0;
    chk("read_accept", got, 1'b1);
    step();
  endtask

  task automatic rand_phase(input int n);
    for (int c = 0; c < n; c++) begin
      step();
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) rst = 1;
      if (!awvalid || aw_acc_now) begin
        awvalid = ($urandom_range(0, 2) != 0);
        awaddr  = 5'($urandom_range(0, 31));
      end
      if (!wvalid || w_acc_now) begin
        wvalid = ($urandom_range(0, 2) != 0);
        wdata  = $urandom;
        wstrb  = 4'($urandom_range(0, 15));
      end
      if (!arvalid || ar_acc_now) begin
        arvalid = ($urandom_range(0, 1) != 0);
        araddr  = 5'($urandom_range(0, 31));
      end
      bready = ($urandom_range(0, 3) != 0);
      rready = ($urandom_range(0, 3) != 0);
    end
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1; rst = 0;
    repeat (4) step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) step();
    @(negedge clk);
    chk("rst_awready", awready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    step();
    rst = 0;
    @(negedge clk);
    chk("post_rst_awready", awready, 1'b1);
    chk("post_rst_wready",  wready,  1'b1);
    chk("post_rst_arready", arready, 1'b1);
    chk("post_rst_bvalid",  bvalid,  1'b0);
    chk("post_rst_rvalid",  rvalid,  1'b0);
    chk("post_rst_resps",   {bresp, rresp}, 4'b0);
    chk("post_rst_rdata",   rdata,   32'h0);
    chk("post_rst_regs",    reg_out, 128'h0);
    step();

    for (int i = 0; i < 4; i++) axi_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(4 * i));
      chk("readback", last_rdata, 32'(i + 1));
      chk("readback_resp", last_rresp, 2'b00);
    end
    chk("reg_out_1234", reg_out, {32'd4, 32'd3, 32'd2, 32'd1});

    axi_write(5'h04, 32'hAABBCCDD, 4'hF, 0, 3);
    axi_write(5'h08, 32'h00000055, 4'hF, 3, 0);
    axi_write(5'h04, 32'h11223344, 4'b0101, 0, 0);
    axi_read(5'h04);
    chk("strb_merge", last_rdata, 32'hAA22CC44);
    axi_write(5'h08, 32'hFFFFFFFF, 4'b0000, 0, 0);
    chk("strb_zero_resp", last_bresp, 2'b00);
    axi_read(5'h08);
    chk("strb_zero_keep", last_rdata, 32'h00000055);

    // Back-pressured response while a second write waits at the channel.
    bready = 0;
    awaddr = 5'h0C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    step();
    awaddr = 5'h00; wdata = 32'h99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_bvalid", bvalid, 1'b1);
      chk("bp_bresp", bresp, 2'b00);
      chk("bp_readies", {awready, wready}, 2'b00);
      chk("bp_reg0", reg_out[31:0], 32'd1);
      step();
    end
    bready = 1;
    step();
    step();
    awvalid = 0; wvalid = 0;
    step();
    axi_read(5'h00);
    chk("second_write", last_rdata, 32'h99);

    axi_write(5'h10, 32'hDEAD, 4'hF, 0, 0);
    chk("slverr_bresp", last_bresp, 2'b10);
    axi_read(5'h10);
    chk("slverr_rdata", last_rdata, 32'h0);
    chk("slverr_rresp", last_rresp, 2'b10);
    chk("slverr_regs", reg_out, {32'h77, 32'h55, 32'hAA22CC44, 32'h99});

`ifdef ALARM_AXIL_WR_PULSE_EN
    pulse_cycles = 0;
    axi_write(5'h08, 32'h1234, 4'hF, 0, 0);
    repeat (3) step();
    chk("pulse_cycles", pulse_cycles, 1);
    chk("pulse_bits", last_pulse, 4'b0100);
`endif

    rready = 0;
    araddr = 5'h04; arvalid = 1;
    step();
    arvalid = 0;
    @(negedge clk);
    chk("pre_rst_rvalid", rvalid, 1'b1);
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("rst_mid_rvalid", rvalid, 1'b0);
    chk("rst_mid_regs", reg_out, 128'h0);
    chk("rst_mid_arready", arready, 1'b1);
    rready = 1;
    step();

    rand_phase(3000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
